// File: rtl/mult_arbiter_if.sv
// Bundle shared by the mult arbiter: requester side, consumer side, and the
// link to the single shared mult unit. The arbiter connects through 'slave';
// the surrounding requesters, consumer and mult unit use 'master'.
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 64
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*XLEN-1:0] req_mcand;
  logic [NUM_REQ*XLEN-1:0] req_mplier;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    resp_valid;
  logic [ID_W-1:0]         resp_id;
  logic [XLEN-1:0]         resp_product;
  logic                    resp_ready;
  logic                    mult_start;
  logic [XLEN-1:0]         mult_mcand;
  logic [XLEN-1:0]         mult_mplier;
  logic [XLEN-1:0]         mult_product;
  logic                    mult_done;

  modport slave (
    input  req_valid, req_mcand, req_mplier, resp_ready, mult_product, mult_done,
    output req_ready, resp_valid, resp_id, resp_product, mult_start, mult_mcand, mult_mplier
  );

  modport master (
    output req_valid, req_mcand, req_mplier, resp_ready, mult_product, mult_done,
    input  req_ready, resp_valid, resp_id, resp_product, mult_start, mult_mcand, mult_mplier
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mult unit among NUM_REQ
// requesters. One operation is in flight at a time: grant, issue, wait for
// the unit, then hold the result until the consumer takes it.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  mult_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_product;
  logic            r_mult_start;
  logic            r_resp_valid;
  logic            r_busy_first;

  logic [XLEN-1:0]    w_mcand_arr  [NUM_REQ];
  logic [XLEN-1:0]    w_mplier_arr [NUM_REQ];
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_winner;
  logic               w_any;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_mcand_arr[g]  = bus.req_mcand[g*XLEN +: XLEN];
    assign w_mplier_arr[g] = bus.req_mplier[g*XLEN +: XLEN];
  end

  // Round-robin search: the pending request at the smallest offset from r_rr_ptr wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = ID_W'(w_sum - (ID_W+1)'(NUM_REQ));
      end else begin
        w_idx = ID_W'(w_sum);
      end
      if (bus.req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end else begin
        w_any    = w_any;
        w_winner = w_winner;
      end
    end
  end

  // Grant only while idle and out of reset, so a held request cannot slip in during reset.
  always_comb begin
    if ((r_state == IDLE) && reset_n && w_any) begin
      w_grant = ONE << w_winner;
    end else begin
      w_grant = '0;
    end
  end

  // Pointer moves to the requester just after the one that was served.
  always_comb begin
    if (r_id == ID_W'(NUM_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = r_id + ID_W'(1);
    end
  end

  // Control FSM: every output except the grant comes straight from these registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_product    <= '0;
      r_mult_start <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy_first <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id         <= w_winner;
            r_mcand      <= w_mcand_arr[w_winner];
            r_mplier     <= w_mplier_arr[w_winner];
            r_mult_start <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_mult_start <= 1'b0;
          r_busy_first <= 1'b1;
          r_state      <= BUSY;
        end
        BUSY: begin
          // A done seen in the first busy cycle belongs to an older operation.
          if (r_busy_first) begin
            r_busy_first <= 1'b0;
          end else if (bus.mult_done) begin
            r_product    <= bus.mult_product;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_mult_start <= 1'b0;
          r_resp_valid <= 1'b0;
          r_busy_first <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = w_grant;
  assign bus.mult_start   = r_mult_start;
  assign bus.mult_mcand   = r_mcand;
  assign bus.mult_mplier  = r_mplier;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_id      = r_id;
  assign bus.resp_product = r_product;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and random bench for mult_arbiter with a behavioural mult unit
// that also raises a stale done in the first busy cycle.
module tb_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int XLEN    = 64;
  localparam int LAT     = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  mult_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  mult_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_lat = 0;
  int          start_cnt = 0;
  logic        prev_rv = 1'b0;
  logic [3:0]  gnt_mark = '0;
  logic        auto_rel = 1'b1;
  logic        rr_check_en = 1'b0;
  int          wait_cnt [NUM_REQ];
  int          grant_q [$];
  int          eid_q [$];
  logic [63:0] eprod_q [$];
  int          rid_q [$];
  logic [63:0] rprod_q [$];

  // Sample everything on the falling edge, away from the DUT's active edge.
  always @(negedge clock) begin
    int gidx;
    logic [63:0] a_m, b_m;
    cyc++;
    gnt_mark = bus.req_valid & bus.req_ready;
    if (bus.mult_start) start_cnt++;
    if (bus.resp_valid && !prev_rv) last_lat = cyc - acc_cyc;
    prev_rv = bus.resp_valid;
    if (bus.resp_valid && bus.resp_ready) begin
      rid_q.push_back(int'(bus.resp_id));
      rprod_q.push_back(bus.resp_product);
    end
    if (gnt_mark != 4'b0000) begin
      check("ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
      gidx = 0;
      for (int i = 0; i < NUM_REQ; i++) if (gnt_mark[i]) gidx = i;
      acc_cyc = cyc;
      a_m = bus.req_mcand[gidx*XLEN +: XLEN];
      b_m = bus.req_mplier[gidx*XLEN +: XLEN];
      grant_q.push_back(gidx);
      eid_q.push_back(gidx);
      eprod_q.push_back(a_m * b_m);
      if (rr_check_en) check("rr_wait", 64'(wait_cnt[gidx] <= NUM_REQ - 1), 64'd1);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == gidx) wait_cnt[j] = 0;
        else if (bus.req_valid[j]) wait_cnt[j]++;
      end
    end
  end

  // Behavioural mult unit: stale done with a wrong product one cycle after
  // start, then the true product LAT-1 cycles later.
  initial begin
    int          m_cnt;
    logic [63:0] m_prod;
    m_cnt = 0;
    m_prod = '0;
    bus.mult_done = 1'b0;
    bus.mult_product = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        m_cnt = 0;
        bus.mult_done = 1'b0;
      end else if (bus.mult_start) begin
        m_prod = bus.mult_mcand * bus.mult_mplier;
        m_cnt = LAT;
        bus.mult_done = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == LAT - 1) begin
          bus.mult_done = 1'b1;
          bus.mult_product = ~m_prod;
        end else if (m_cnt == 0) begin
          bus.mult_done = 1'b1;
          bus.mult_product = m_prod;
        end else begin
          bus.mult_done = 1'b0;
        end
      end else begin
        bus.mult_done = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (auto_rel) bus.req_valid = bus.req_valid & ~gnt_mark;
  endtask

  task automatic set_ops(input int id, input logic [63:0] a, input logic [63:0] b);
    bus.req_mcand[id*XLEN +: XLEN]  = a;
    bus.req_mplier[id*XLEN +: XLEN] = b;
  endtask

  task automatic wait_resp(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rid_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_count"}, 64'(rid_q.size()), 64'(n));
  endtask

  task automatic clear_q();
    grant_q.delete(); eid_q.delete(); eprod_q.delete();
    rid_q.delete(); rprod_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_q();
  endtask

  // Single request from an idle arbiter; called at posedge+1.
  task automatic run_single(input string tag, input int id, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp_prod);
    int n0, s0;
    logic [3:0] exp_rdy;
    n0 = rid_q.size();
    s0 = start_cnt;
    exp_rdy = 4'b0001 << id;
    set_ops(id, a, b);
    bus.req_valid[id] = 1'b1;
    @(negedge clock);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    step();
    check({tag, "_start"}, 64'(bus.mult_start), 64'd1);
    check({tag, "_mcand"}, bus.mult_mcand, a);
    wait_resp(tag, n0 + 1, 40);
    if (rid_q.size() > n0) begin
      check({tag, "_id"}, 64'(rid_q[n0]), 64'(id));
      check({tag, "_prod"}, rprod_q[n0], exp_prod);
    end
    check({tag, "_pulses"}, 64'(start_cnt - s0), 64'd1);
    check({tag, "_latency"}, 64'(last_lat), 64'd5);
  endtask

  initial begin
    int k, n0;
    logic [63:0] exp_p [5];
    int exp_i [5];
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    bus.req_valid  = '0;
    bus.req_mcand  = '0;
    bus.req_mplier = '0;
    bus.resp_ready = 1'b1;

    // Asynchronous reset, checked before any clock edge, with a request pending.
    #1;
    reset_n = 1'b0;
    bus.req_valid = 4'b0001;
    #2;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_mult_start", 64'(bus.mult_start), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_id", 64'(bus.resp_id), 64'd0);
    check("rst_resp_product", bus.resp_product, 64'd0);
    check("rst_mult_mcand", bus.mult_mcand, 64'd0);
    bus.req_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_q();

    // Basic operations
    run_single("t32", 0, 64'd2, 64'd3, 64'd6);
    run_single("t33", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD);

    // Round robin: pointer is 2, so 3 beats 0, then 0 follows.
    clear_q();
    set_ops(0, 64'd4, 64'd4);
    set_ops(3, 64'd5, 64'd5);
    bus.req_valid = 4'b1001;
    @(negedge clock);
    check("rr_ready", 64'(bus.req_ready), 64'b1000);
    wait_resp("rr", 2, 60);
    if (rid_q.size() >= 2) begin
      check("rr_id0", 64'(rid_q[0]), 64'd3);
      check("rr_prod0", rprod_q[0], 64'd25);
      check("rr_id1", 64'(rid_q[1]), 64'd0);
      check("rr_prod1", rprod_q[1], 64'd16);
    end

    // All four held high from reset.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 64'(10 + i), 64'(100 + i));
    exp_i = '{0, 1, 2, 3, 0};
    exp_p = '{64'd1000, 64'd1111, 64'd1224, 64'd1339, 64'd1000};
    auto_rel = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clock);
    check("t34_first_ready", 64'(bus.req_ready), 64'b0001);
    k = 0;
    while (grant_q.size() < 5 && k < 100) begin
      step();
      k++;
    end
    bus.req_valid = '0;
    auto_rel = 1'b1;
    wait_resp("t34", 5, 60);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_q.size()) check("t34_grant", 64'(grant_q[i]), 64'(exp_i[i]));
      if (i < rid_q.size()) begin
        check("t34_id", 64'(rid_q[i]), 64'(exp_i[i]));
        check("t34_prod", rprod_q[i], exp_p[i]);
      end
    end

    // Back-pressure in RESP; pointer is 1, req2 wins over req0.
    clear_q();
    bus.resp_ready = 1'b0;
    set_ops(2, 64'hFFFF_FFFF_FFFF_FFEC, 64'd5);
    set_ops(0, 64'd9, 64'd9);
    bus.req_valid = 4'b0101;
    @(negedge clock);
    check("t35_ready", 64'(bus.req_ready), 64'b0100);
    k = 0;
    while (!bus.resp_valid && k < 40) begin
      step();
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      check("t35_rv", 64'(bus.resp_valid), 64'd1);
      check("t35_prod", bus.resp_product, 64'hFFFF_FFFF_FFFF_FF9C);
      check("t35_id", 64'(bus.resp_id), 64'd2);
      check("t35_noready", 64'(bus.req_ready), 64'd0);
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    check("t35_regrant", 64'(bus.req_ready), 64'b0001);
    wait_resp("t35", 2, 40);
    if (rid_q.size() >= 2) begin
      check("t35_id_first", 64'(rid_q[0]), 64'd2);
      check("t35_prod_first", rprod_q[0], 64'hFFFF_FFFF_FFFF_FF9C);
      check("t35_prod_next", rprod_q[1], 64'd81);
    end

    // Reset while busy.
    set_ops(1, 64'd5, 64'd5);
    bus.req_valid[1] = 1'b1;
    n0 = start_cnt;
    k = 0;
    while (start_cnt == n0 && k < 20) begin
      step();
      k++;
    end
    step();
    bus.req_valid[3] = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t36_req_ready", 64'(bus.req_ready), 64'd0);
    check("t36_mult_start", 64'(bus.mult_start), 64'd0);
    check("t36_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("t36_resp_product", bus.resp_product, 64'd0);
    check("t36_mult_mcand", bus.mult_mcand, 64'd0);
    check("t36_mult_mplier", bus.mult_mplier, 64'd0);
    bus.req_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_q();
    run_single("t36", 2, 64'd7, 64'd6, 64'd42);
    check("t36_no_stale", 64'(rid_q.size()), 64'd1);

    // Random traffic against the scoreboard.
    clear_q();
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    rr_check_en = 1'b1;
    auto_rel = 1'b0;
    k = 0;
    while (grant_q.size() < 60 && k < 3000) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_mark[i]) begin
          set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
        end else if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
            bus.req_valid[i] = 1'b1;
            wait_cnt[i] = 0;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          bus.req_valid[i] = 1'b0;
          wait_cnt[i] = 0;
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    auto_rel = 1'b1;
    rr_check_en = 1'b0;
    check("t37_grants", 64'(grant_q.size() >= 60), 64'd1);
    wait_resp("t37", eid_q.size(), 100);
    for (int i = 0; i < eid_q.size(); i++) begin
      if (i < rid_q.size()) begin
        check("t37_id", 64'(rid_q[i]), 64'(eid_q[i]));
        check("t37_prod", rprod_q[i], eprod_q[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
